// File: rtl/secuenciador_mac_pkg.sv
// Shared types and constants for the MAC sequencer datapath.
// Word format: sign-magnitude, bit W-1 sign, FRAC fractional bits.
package secuenciador_mac_pkg;
    localparam int W_DEF    = 25;
    localparam int FRAC_DEF = 16;
    localparam int SGN_BIT  = W_DEF - 1;
    localparam logic [W_DEF-1:0] POS_ZERO = '0;
    localparam logic [W_DEF-2:0] MAX_MAG  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DESPLAZA = 2'd1,
        TERM     = 2'd2
    } state_t;
endpackage

// File: rtl/secuenciador_mac_if.sv
// Sample/coefficient inputs and term outputs of the MAC sequencer.
// The sat wire exists only when SEC_SAT_EN is defined.
interface secuenciador_mac_if
    import secuenciador_mac_pkg::*;
#(
    parameter int N_TAPS = 5,
    parameter int W      = W_DEF
);
    localparam int AW = $clog2(N_TAPS);

    logic [W-1:0]  muestra_in;
    logic          muestra_valida;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data;
    logic [W-1:0]  in_acc;
    logic          term_valida;
    logic          listo;
    logic          ocupado;
`ifdef SEC_SAT_EN
    logic          sat;
`endif

    modport master (
        output muestra_in, muestra_valida,
        output coef_we, coef_addr, coef_data,
        input  in_acc, term_valida, listo, ocupado
`ifdef SEC_SAT_EN
        , input sat
`endif
    );

    modport slave (
        input  muestra_in, muestra_valida,
        input  coef_we, coef_addr, coef_data,
        output in_acc, term_valida, listo, ocupado
`ifdef SEC_SAT_EN
        , output sat
`endif
    );
endinterface

// File: rtl/secuenciador_mac_multiplicador_sm.sv
// Combinational sign-magnitude multiply with fixed-point rescale.
// SEC_SAT_EN selects clamp-on-overflow instead of wrap.
module multiplicador_sm
    import secuenciador_mac_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic [W-1:0] c,
    input  logic [W-1:0] x,
`ifdef SEC_SAT_EN
    output logic         sat,
`endif
    output logic [W-1:0] y
);
    localparam int M = W - 1;

    logic [2*M-1:0] prod;
    logic [M-1:0]   mag;
    logic           sgn;
    logic           unused_bits;

    assign prod = {{M{1'b0}}, c[M-1:0]} * {{M{1'b0}}, x[M-1:0]};
    assign sgn  = c[M] ^ x[M];

`ifdef SEC_SAT_EN
    logic ovf;
    assign ovf         = |prod[2*M-1:FRAC+M];
    assign mag         = ovf ? '1 : prod[FRAC+M-1:FRAC];
    assign sat         = ovf;
    assign unused_bits = ^prod[FRAC-1:0];
`else
    assign mag         = prod[FRAC+M-1:FRAC];
    assign unused_bits = ^{prod[2*M-1:FRAC+M], prod[FRAC-1:0]};
`endif

    // Any zero magnitude leaves as +0 so -0 never reaches the accumulator
    assign y = (mag == '0) ? '0 : {sgn, mag};
endmodule

// File: rtl/secuenciador_mac.sv
// Per-sample sequencer: shifts the delay line then streams N_TAPS terms.
// Define SEC_SAT_EN for saturating products and the sat output.
module secuenciador_mac
    import secuenciador_mac_pkg::*;
#(
    parameter int N_TAPS = 5,
    parameter int W      = W_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input logic               clk,
    input logic               rst,
    secuenciador_mac_if.slave bus
);
    localparam int AW = $clog2(N_TAPS);
    localparam logic [AW-1:0] LAST = AW'(N_TAPS - 1);

    state_t        state;
    logic [AW-1:0] k;
    logic [AW-1:0] nidx;
    logic [W-1:0]  samp;
    logic [W-1:0]  x    [N_TAPS];
    logic [W-1:0]  coef [N_TAPS];
    logic [W-1:0]  op_x;
    logic [W-1:0]  term;
`ifdef SEC_SAT_EN
    logic          term_sat;
`endif

    // The output register is loaded one cycle ahead, so the multiplier
    // looks at the tap that will be shown next (tap 0 during DESPLAZA).
    assign nidx = (state == DESPLAZA || k == LAST) ? '0 : k + 1'b1;
    assign op_x = (state == DESPLAZA) ? samp : x[nidx];

    multiplicador_sm #(.W(W), .FRAC(FRAC)) u_mul (
        .c   (coef[nidx]),
        .x   (op_x),
`ifdef SEC_SAT_EN
        .sat (term_sat),
`endif
        .y   (term)
    );

    // Sequencer FSM with delay line, coefficient bank and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            k               <= '0;
            samp            <= POS_ZERO;
            bus.in_acc      <= POS_ZERO;
            bus.term_valida <= 1'b0;
            bus.listo       <= 1'b0;
            bus.ocupado     <= 1'b0;
`ifdef SEC_SAT_EN
            bus.sat         <= 1'b0;
`endif
            for (int i = 0; i < N_TAPS; i++) begin
                x[i]    <= POS_ZERO;
                coef[i] <= POS_ZERO;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    bus.term_valida <= 1'b0;
                    bus.listo       <= 1'b0;
                    if (bus.coef_we && int'(bus.coef_addr) < N_TAPS)
                        coef[bus.coef_addr] <= bus.coef_data;
                    if (bus.muestra_valida) begin
                        samp        <= bus.muestra_in;
                        bus.ocupado <= 1'b1;
                        state       <= DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    x[0] <= samp;
                    for (int i = 1; i < N_TAPS; i++)
                        x[i] <= x[i-1];
                    bus.in_acc      <= term;
                    bus.term_valida <= 1'b1;
                    bus.listo       <= 1'b0;
`ifdef SEC_SAT_EN
                    bus.sat         <= term_sat;
`endif
                    k               <= '0;
                    state           <= TERM;
                end
                TERM: begin
                    if (k == LAST) begin
                        bus.term_valida <= 1'b0;
                        bus.listo       <= 1'b0;
                        bus.ocupado     <= 1'b0;
`ifdef SEC_SAT_EN
                        bus.sat         <= 1'b0;
`endif
                        state           <= IDLE;
                    end else begin
                        bus.in_acc <= term;
                        bus.listo  <= (nidx == LAST);
`ifdef SEC_SAT_EN
                        bus.sat    <= term_sat;
`endif
                        k          <= nidx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_secuenciador_mac.sv
// Self-checking bench for secuenciador_mac against a tap-level model.
// Honours SEC_SAT_EN the same way as the design.
module tb_secuenciador_mac;
    localparam int N    = 5;
    localparam int W    = 25;
    localparam int FRAC = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    secuenciador_mac_if #(.N_TAPS(N), .W(W)) bus ();

    secuenciador_mac #(.N_TAPS(N), .W(W), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    logic [W-1:0] mx [N];
    logic [W-1:0] mc [N];

    function automatic logic [W-1:0] ref_term(input logic [W-1:0] c,
                                               input logic [W-1:0] xv,
                                               output bit s);
        longint unsigned p;
        longint unsigned m;
        p = c[W-2:0];
        p = p * xv[W-2:0];
        m = p >> FRAC;
        s = 1'b0;
`ifdef SEC_SAT_EN
        if (m > 64'hFF_FFFF) begin
            m = 64'hFF_FFFF;
            s = 1'b1;
        end
`else
        m = m % 64'h100_0000;
`endif
        if (m == 0) return '0;
        return {c[W-1] ^ xv[W-1], m[W-2:0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mx[i] = '0;
            mc[i] = '0;
        end
    endtask

    task automatic write_coef(input int a, input logic [W-1:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'(a);
        bus.coef_data = d;
        mc[a] = d;
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic run_seq(input string nm, input logic [W-1:0] s,
                           input bit pulse, input bit wc,
                           input int wa, input logic [W-1:0] wd);
        logic [W-1:0] e  [N];
        bit           es [N];
        bus.muestra_in     = s;
        bus.muestra_valida = 1'b1;
        if (wc) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 3'(wa);
            bus.coef_data = wd;
            mc[wa] = wd;
        end
        for (int i = N - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = s;
        for (int i = 0; i < N; i++) e[i] = ref_term(mc[i], mx[i], es[i]);
        @(negedge clk);
        bus.muestra_valida = 1'b0;
        bus.coef_we        = 1'b0;
        total++;
        if ({bus.ocupado, bus.term_valida, bus.listo} !== 3'b100)
            $display("FAIL %s shift got=%b exp=100", nm,
                     {bus.ocupado, bus.term_valida, bus.listo});
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            total++;
            if ({bus.in_acc, bus.term_valida, bus.listo, bus.ocupado} !==
                {e[i], 1'b1, (i == N - 1), 1'b1})
                $display("FAIL %s term%0d got=%h/%b/%b/%b exp=%h/1/%b/1",
                         nm, i, bus.in_acc, bus.term_valida, bus.listo,
                         bus.ocupado, e[i], (i == N - 1));
            else pass_cnt++;
`ifdef SEC_SAT_EN
            total++;
            if (bus.sat !== es[i])
                $display("FAIL %s sat%0d got=%b exp=%b", nm, i, bus.sat, es[i]);
            else pass_cnt++;
`endif
            if (pulse) begin
                bus.muestra_valida = (i == 1);
                bus.muestra_in     = W'($urandom);
                bus.coef_we        = (i == 1);
                bus.coef_addr      = '0;
                bus.coef_data      = W'($urandom);
            end
        end
        @(negedge clk);
        bus.muestra_valida = 1'b0;
        bus.coef_we        = 1'b0;
        total++;
        if ({bus.ocupado, bus.term_valida, bus.listo, bus.in_acc} !==
            {3'b000, e[N-1]})
            $display("FAIL %s idle got=%b/%h exp=000/%h", nm,
                     {bus.ocupado, bus.term_valida, bus.listo},
                     bus.in_acc, e[N-1]);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.in_acc, bus.term_valida, bus.listo, bus.ocupado} !== '0)
            $display("FAIL reset_hold got=%h/%b/%b/%b exp=0/0/0/0",
                     bus.in_acc, bus.term_valida, bus.listo, bus.ocupado);
        else pass_cnt++;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        total++;
        if ({bus.in_acc, bus.term_valida, bus.listo, bus.ocupado} !== '0)
            $display("FAIL reset_release got=%h/%b/%b/%b exp=0/0/0/0",
                     bus.in_acc, bus.term_valida, bus.listo, bus.ocupado);
        else pass_cnt++;
    endtask

    task automatic test_identity();
        write_coef(0, 25'h0010000);
        run_seq("identity", 25'h0020000, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_negative();
        write_coef(0, 25'h1010000);
        run_seq("negative", 25'h0030000, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_neg_zero();
        write_coef(0, 25'h1000000);
        run_seq("neg_zero", 25'h0050000, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_overflow();
        run_seq("overflow", 25'h0FF0000, 1'b0, 1'b1, 0, 25'h0FF0000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) write_coef(i, 25'h0010000);
        run_seq("b2b_first", 25'h0010000, 1'b0, 1'b0, 0, '0);
        run_seq("b2b_second", 25'h0020000, 1'b1, 1'b0, 0, '0);
        @(negedge clk);
        run_seq("b2b_after", 25'h0040000, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_reset_mid();
        bus.muestra_in     = 25'h0030000;
        bus.muestra_valida = 1'b1;
        @(negedge clk);
        bus.muestra_valida = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({bus.in_acc, bus.term_valida, bus.listo, bus.ocupado} !== '0)
            $display("FAIL reset_mid got=%h/%b/%b/%b exp=0/0/0/0",
                     bus.in_acc, bus.term_valida, bus.listo, bus.ocupado);
        else pass_cnt++;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) write_coef(i, 25'h0010000);
        run_seq("post_reset", 25'h0010000, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [W-1:0] s;
            logic [W-1:0] d;
            int           a;
            a = int'($urandom_range(N - 1, 0));
            d = W'($urandom);
            if ($urandom_range(3, 0) == 0) d[W-2:FRAC+2] = '0;
            if ($urandom_range(1, 0) == 0) write_coef(a, d);
            s = W'($urandom);
            if ($urandom_range(3, 0) == 0) s[W-2:FRAC+1] = '0;
            if ($urandom_range(7, 0) == 0) s = 25'h1000000;
            d = W'($urandom);
            run_seq("random", s, 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)),
                    int'($urandom_range(N - 1, 0)), d);
            if ($urandom_range(1, 0) == 0) @(negedge clk);
        end
    endtask

    initial begin
        bus.muestra_in     = '0;
        bus.muestra_valida = 1'b0;
        bus.coef_we        = 1'b0;
        bus.coef_addr      = '0;
        bus.coef_data      = '0;
        test_reset();
        test_identity();
        test_negative();
        test_neg_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
